// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_ctrl_pkg
// Brief   : Opcode constants, select encodings and helpers for the RV32I
//           multicycle control unit.
// Revision: 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'd3;
    localparam logic [6:0] OPC_FENCE  = 7'd15;
    localparam logic [6:0] OPC_OPIMM  = 7'd19;
    localparam logic [6:0] OPC_AUIPC  = 7'd23;
    localparam logic [6:0] OPC_STORE  = 7'd35;
    localparam logic [6:0] OPC_OP     = 7'd51;
    localparam logic [6:0] OPC_LUI    = 7'd55;
    localparam logic [6:0] OPC_BRANCH = 7'd99;
    localparam logic [6:0] OPC_JALR   = 7'd103;
    localparam logic [6:0] OPC_JAL    = 7'd111;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd7
    } imm_type_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0,
        PC_IMM   = 2'd1,
        PC_ALU   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MDR = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_a_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_FUNCT = 2'd1,
        ALU_CMP   = 2'd2
    } alu_op_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: return IMM_I;
            OPC_STORE:                     return IMM_S;
            OPC_BRANCH:                    return IMM_B;
            OPC_AUIPC, OPC_LUI:            return IMM_U;
            OPC_JAL:                       return IMM_J;
            default:                       return IMM_NONE;
        endcase
    endfunction

    // SYSTEM is deliberately absent: it traps as illegal in this core.
    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_FENCE: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : rv_mem_watchdog
// Brief   : Counts consecutive stalled memory-request cycles and flags a bus
//           timeout when the limit is reached without completion.
// Revision: 1.0 - initial release
// ============================================================================
module rv_mem_watchdog #(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [TIMEOUT_W-1:0] c_limit = TIMEOUT_W'(MEM_TIMEOUT);

    logic [TIMEOUT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!mem_req || mem_ready) begin
            r_count <= '0;
        end else if (r_count != c_limit) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    // A ready arriving in the limit cycle still completes normally.
    assign timeout = mem_req && !mem_ready && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : rv_mc_ctrl
// Brief   : Multicycle RV32I main control FSM with shared-memory arbitration
//           between fetch and load/store, plus bus-timeout trap.
// Revision: 1.0 - initial release
// ============================================================================
module rv_mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W   = 8,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       mdr_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [2:0] imm_type,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       illegal,
    output logic       bus_err
);

    ctrl_state_e r_state;
    ctrl_state_e w_next;
    logic        r_br_q;
    logic        r_illegal;
    logic        r_bus_err;
    logic        w_mem_req;
    logic        w_timeout;

    // Kept outside the FSM process so the watchdog feedback is not a loop.
    assign w_mem_req = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign mem_req   = w_mem_req;
    assign illegal   = r_illegal;
    assign bus_err   = r_bus_err;

    rv_mem_watchdog #(
        .TIMEOUT_W   (TIMEOUT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (w_mem_req),
        .mem_ready (mem_ready),
        .timeout   (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_br_q    <= 1'b0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_EXEC && opcode == OPC_BRANCH) begin
                r_br_q <= br_taken;
            end
            if (r_state == ST_DECODE && !opcode_legal(opcode)) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_PLUS4;
        imm_type  = IMM_NONE;
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = 1'b0;
        alu_op    = ALU_ADD;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        retire    = 1'b0;

        case (r_state)
            ST_IDLE: w_next = ST_FETCH;

            ST_FETCH: begin
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    w_next = ST_DECODE;
                end else if (w_timeout) begin
                    w_next = ST_TRAP;
                end
            end

            ST_DECODE: begin
                imm_type = imm_type_of(opcode);
                w_next   = opcode_legal(opcode) ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                imm_type = imm_type_of(opcode);
                w_next   = ST_WB;
                case (opcode)
                    OPC_OP: begin
                        alu_op = ALU_FUNCT;
                    end
                    OPC_OPIMM: begin
                        alu_b_sel = 1'b1;
                        alu_op    = ALU_FUNCT;
                    end
                    OPC_LUI: begin
                        alu_a_sel = ALU_A_ZERO;
                        alu_b_sel = 1'b1;
                    end
                    OPC_AUIPC: begin
                        alu_a_sel = ALU_A_PC;
                        alu_b_sel = 1'b1;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_b_sel = 1'b1;
                        w_next    = ST_MEM;
                    end
                    OPC_JALR: begin
                        alu_b_sel = 1'b1;
                    end
                    OPC_BRANCH: begin
                        alu_op = ALU_CMP;
                    end
                    default: ;
                endcase
            end

            ST_MEM: begin
                imm_type = imm_type_of(opcode);
                addr_sel = 1'b1;
                mem_we   = (opcode == OPC_STORE);
                if (mem_ready) begin
                    mdr_we = (opcode == OPC_LOAD);
                    w_next = ST_WB;
                end else if (w_timeout) begin
                    w_next = ST_TRAP;
                end
            end

            ST_WB: begin
                imm_type = imm_type_of(opcode);
                pc_we    = 1'b1;
                retire   = 1'b1;
                w_next   = ST_FETCH;
                if (opcode == OPC_JAL || (opcode == OPC_BRANCH && r_br_q)) begin
                    pc_src = PC_IMM;
                end else if (opcode == OPC_JALR) begin
                    pc_src = PC_ALU;
                end
                case (opcode)
                    OPC_LOAD, OPC_OPIMM, OPC_AUIPC, OPC_OP,
                    OPC_LUI, OPC_JALR, OPC_JAL: rf_we = 1'b1;
                    default:                    rf_we = 1'b0;
                endcase
                if (opcode == OPC_LOAD) begin
                    wb_sel = WB_MDR;
                end else if (opcode == OPC_JAL || opcode == OPC_JALR) begin
                    wb_sel = WB_PC4;
                end
            end

            ST_TRAP: w_next = ST_TRAP;

            default: w_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire
